// File: rtl/wasm_local_stack_if.sv
// Op request / top-of-stack bus between the wasm core decode stage and the local stack unit.
interface wasm_local_stack_if #(
    parameter int STACK_DEPTH = 7,
    parameter int TYPE_W      = 2
);
    logic [2:0]             op;
    logic                   op_valid;
    logic                   op_ready;
    logic [63:0]            op_data;
    logic [TYPE_W-1:0]      op_type;
    logic [STACK_DEPTH:0]   op_index;
    logic [STACK_DEPTH:0]   op_count;
    logic [63:0]            top;
    logic [TYPE_W-1:0]      top_type;
    logic                   top_empty;
    logic [STACK_DEPTH:0]   sp;
    logic [3:0]             trap;

    modport master (
        output op, op_valid, op_data, op_type, op_index, op_count,
        input  op_ready, top, top_type, top_empty, sp, trap
    );

    modport slave (
        input  op, op_valid, op_data, op_type, op_index, op_count,
        output op_ready, top, top_type, top_empty, sp, trap
    );
endinterface

// File: rtl/wasm_local_stack.sv
// Operand stack plus frame-relative locals: typed 64-bit entries, nested ENTER/LEAVE
// frames with multi-cycle zero-fill of declared locals, sticky trap reporting.
module wasm_local_stack #(
    parameter int STACK_DEPTH = 7,
    parameter int FRAME_DEPTH = 3,
    parameter bit USE_64B     = 1'b1,
    parameter int TYPE_W      = 2
) (
    input  logic              clk,
    input  logic              reset,
    wasm_local_stack_if.slave bus
);
    localparam int IW  = STACK_DEPTH + 1;
    // Pointers carry two extra bits so sp == capacity and sp + count stay representable.
    localparam int PW  = STACK_DEPTH + 3;
    localparam int CAP = 1 << IW;
    localparam int NF  = 1 << FRAME_DEPTH;
    localparam logic [PW-1:0]          CAP_P = PW'(CAP);
    localparam logic [PW-1:0]          ONE_P = PW'(1);
    localparam logic [FRAME_DEPTH:0]   NF_L  = (FRAME_DEPTH+1)'(NF);

    localparam logic [3:0] T_NONE = 4'd0, T_OVF = 4'd1, T_UNF = 4'd2, T_OOB = 4'd3,
                           T_NO64 = 4'd4, T_FOVF = 4'd5, T_FUNF = 4'd6;

    typedef enum logic [2:0] {
        OP_NOP, OP_PUSH, OP_POP, OP_GET, OP_SET, OP_TEE, OP_ENTER, OP_LEAVE
    } op_e;
    typedef enum logic [1:0] {IDLE, FILL, HALT} state_e;

    state_e               state_q, state_d;
    logic                 live_q;
    logic [PW-1:0]        sp_q, sp_d, fp_q, fp_d, le_q, le_d;
    logic [FRAME_DEPTH:0] lvl_q, lvl_d;
    logic [IW-1:0]        cnt_q, cnt_d;
    logic [63:0]          top_q, top_d;
    logic [TYPE_W-1:0]    ttype_q, ttype_d;
    logic [3:0]           trap_q, trap_d, trap_c;

    logic [63:0]          ram_data [CAP];
    logic [TYPE_W-1:0]    ram_type [CAP];
    logic [PW-1:0]        fr_fp [NF];
    logic [PW-1:0]        fr_le [NF];

    logic                   wr_en, fr_we, accept, empty;
    logic [IW-1:0]          wr_addr, rd_addr;
    logic [63:0]            wr_data, rd_data, push_data;
    logic [TYPE_W-1:0]      wr_type, rd_type;
    logic [FRAME_DEPTH-1:0] fr_wi, fr_ri;
    logic [PW-1:0]          idx_p, cnt_p, loc_p;
    op_e                    opc;

    assign opc       = op_e'(bus.op);
    assign accept    = bus.op_valid && bus.op_ready;
    assign idx_p     = PW'(bus.op_index);
    assign cnt_p     = PW'(bus.op_count);
    assign loc_p     = fp_q + idx_p;
    assign fr_wi     = lvl_q[FRAME_DEPTH-1:0];
    assign fr_ri     = fr_wi - 1'b1;
    assign push_data = bus.op_type[0] ? bus.op_data : {32'b0, bus.op_data[31:0]};

    // Single asynchronous read port, steered by the op being presented.
    always_comb begin
        case (opc)
            OP_GET:   rd_addr = loc_p[IW-1:0];
            OP_LEAVE: rd_addr = fp_q[IW-1:0] - IW'(1);
            default:  rd_addr = sp_q[IW-1:0] - IW'(2);
        endcase
    end
    assign rd_data = ram_data[rd_addr];
    assign rd_type = ram_type[rd_addr];

    // Trap decode; branch order encodes NO_64B > FRAME_* > LOCAL_OOB > OVERFLOW > UNDERFLOW.
    always_comb begin
        trap_c = T_NONE;
        case (opc)
            OP_PUSH: begin
                if (!USE_64B && bus.op_type[0]) trap_c = T_NO64;
                else if (sp_q == CAP_P)         trap_c = T_OVF;
            end
            OP_POP: if (sp_q == le_q) trap_c = T_UNF;
            OP_GET: begin
                if (loc_p >= le_q)       trap_c = T_OOB;
                else if (sp_q == CAP_P)  trap_c = T_OVF;
            end
            OP_SET, OP_TEE: begin
                if (loc_p >= le_q)       trap_c = T_OOB;
                else if (sp_q == le_q)   trap_c = T_UNF;
            end
            OP_ENTER: begin
                if (lvl_q == NF_L)               trap_c = T_FOVF;
                else if (sp_q + cnt_p > CAP_P)   trap_c = T_OVF;
                else if (idx_p > sp_q - le_q)    trap_c = T_UNF;
            end
            OP_LEAVE: if (lvl_q == '0) trap_c = T_FUNF;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        fp_d    = fp_q;
        le_d    = le_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        top_d   = top_q;
        ttype_d = ttype_q;
        trap_d  = trap_q;
        wr_en   = 1'b0;
        wr_addr = sp_q[IW-1:0];
        wr_data = '0;
        wr_type = '0;
        fr_we   = 1'b0;
        case (state_q)
            FILL: begin
                wr_en   = 1'b1;
                sp_d    = sp_q + ONE_P;
                top_d   = '0;
                ttype_d = '0;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == IW'(1)) state_d = IDLE;
            end
            IDLE: if (accept) begin
                if (trap_c != T_NONE) begin
                    trap_d  = trap_c;
                    state_d = HALT;
                end else begin
                    case (opc)
                        OP_PUSH: begin
                            wr_en   = 1'b1;
                            wr_data = push_data;
                            wr_type = bus.op_type;
                            sp_d    = sp_q + ONE_P;
                            top_d   = push_data;
                            ttype_d = bus.op_type;
                        end
                        OP_POP: begin
                            sp_d    = sp_q - ONE_P;
                            top_d   = (sp_q == ONE_P) ? '0 : rd_data;
                            ttype_d = (sp_q == ONE_P) ? '0 : rd_type;
                        end
                        OP_GET: begin
                            wr_en   = 1'b1;
                            wr_data = rd_data;
                            wr_type = rd_type;
                            sp_d    = sp_q + ONE_P;
                            top_d   = rd_data;
                            ttype_d = rd_type;
                        end
                        OP_SET: begin
                            wr_en   = 1'b1;
                            wr_addr = loc_p[IW-1:0];
                            wr_data = top_q;
                            wr_type = ttype_q;
                            sp_d    = sp_q - ONE_P;
                            // The local may be the entry that becomes the new top.
                            if (loc_p != sp_q - PW'(2)) begin
                                top_d   = rd_data;
                                ttype_d = rd_type;
                            end
                        end
                        OP_TEE: begin
                            wr_en   = 1'b1;
                            wr_addr = loc_p[IW-1:0];
                            wr_data = top_q;
                            wr_type = ttype_q;
                        end
                        OP_ENTER: begin
                            fr_we = 1'b1;
                            lvl_d = lvl_q + 1'b1;
                            fp_d  = sp_q - idx_p;
                            le_d  = sp_q + cnt_p;
                            cnt_d = bus.op_count;
                            if (bus.op_count != '0) state_d = FILL;
                        end
                        OP_LEAVE: begin
                            lvl_d = lvl_q - 1'b1;
                            fp_d  = fr_fp[fr_ri];
                            le_d  = fr_le[fr_ri];
                            if (sp_q > le_q) begin
                                wr_en   = 1'b1;
                                wr_addr = fp_q[IW-1:0];
                                wr_data = top_q;
                                wr_type = ttype_q;
                                sp_d    = fp_q + ONE_P;
                            end else begin
                                sp_d    = fp_q;
                                top_d   = (fp_q == '0) ? '0 : rd_data;
                                ttype_d = (fp_q == '0) ? '0 : rd_type;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
            sp_q    <= '0;
            fp_q    <= '0;
            le_q    <= '0;
            lvl_q   <= '0;
            cnt_q   <= '0;
            top_q   <= '0;
            ttype_q <= '0;
            trap_q  <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            sp_q    <= sp_d;
            fp_q    <= fp_d;
            le_q    <= le_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            top_q   <= top_d;
            ttype_q <= ttype_d;
            trap_q  <= trap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_data[wr_addr] <= wr_data;
            ram_type[wr_addr] <= wr_type;
        end
        if (fr_we) begin
            fr_fp[fr_wi] <= fp_q;
            fr_le[fr_wi] <= le_q;
        end
    end

    assign empty         = (sp_q == le_q) || (sp_q == fp_q);
    assign bus.op_ready  = live_q && (state_q == IDLE);
    assign bus.top_empty = empty;
    assign bus.top       = empty ? '0 : top_q;
    assign bus.top_type  = ttype_q;
    assign bus.sp        = sp_q[IW-1:0];
    assign bus.trap      = trap_q;
endmodule

// File: tb/tb_wasm_local_stack.sv
// Directed bench for wasm_local_stack: vector table of op sequences plus hand-written
// reset, capacity, frame nesting, mid-fill reset and USE_64B=0 sequences.
module tb_wasm_local_stack;
    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, GET = 3'd3,
                           SET = 3'd4, TEE = 3'd5, ENT = 3'd6, LEV = 3'd7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wasm_local_stack_if #(.STACK_DEPTH(7), .TYPE_W(2)) ifa ();
    wasm_local_stack_if #(.STACK_DEPTH(7), .TYPE_W(2)) ifb ();

    wasm_local_stack #(.STACK_DEPTH(7), .FRAME_DEPTH(3), .USE_64B(1'b1), .TYPE_W(2)) u_dut (
        .clk(clk), .reset(rst_n), .bus(ifa)
    );
    wasm_local_stack #(.STACK_DEPTH(7), .FRAME_DEPTH(3), .USE_64B(1'b0), .TYPE_W(2)) u_d32 (
        .clk(clk), .reset(rst_n), .bus(ifb)
    );

    typedef struct {
        bit          rst;
        logic [2:0]  op;
        logic [63:0] data;
        logic [1:0]  typ;
        logic [7:0]  idx;
        logic [7:0]  cnt;
        logic [7:0]  e_sp;
        logic [63:0] e_top;
        logic [1:0]  e_type;
        logic        e_empty;
        logic [3:0]  e_trap;
        int          e_stall;
    } vec_t;

    function automatic vec_t mk(bit rst, logic [2:0] op, logic [63:0] d, logic [1:0] t,
                                logic [7:0] i, logic [7:0] c, logic [7:0] sp, logic [63:0] top,
                                logic [1:0] tt, logic em, logic [3:0] tr, int st);
        vec_t v;
        v.rst = rst; v.op = op; v.data = d; v.typ = t; v.idx = i; v.cnt = c;
        v.e_sp = sp; v.e_top = top; v.e_type = tt; v.e_empty = em; v.e_trap = tr; v.e_stall = st;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ifa.op_valid = 1'b0;
        ifb.op_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] op, input logic [63:0] d, input logic [1:0] t,
                         input logic [7:0] i, input logic [7:0] c, input int row);
        int n = 0;
        while (!ifa.op_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_op", row, 64'(ifa.op_ready), 64'd1);
        ifa.op = op; ifa.op_data = d; ifa.op_type = t; ifa.op_index = i; ifa.op_count = c;
        ifa.op_valid = 1'b1;
        @(posedge clk);
        #1 ifa.op_valid = 1'b0;
    endtask

    task automatic drive_b(input logic [63:0] d, input logic [1:0] t);
        @(negedge clk);
        ifb.op = PUSH; ifb.op_data = d; ifb.op_type = t; ifb.op_index = '0; ifb.op_count = '0;
        ifb.op_valid = 1'b1;
        @(posedge clk);
        #1 ifb.op_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int r);
        int stall;
        if (v.rst) do_reset();
        issue(v.op, v.data, v.typ, v.idx, v.cnt, r);
        @(negedge clk);
        stall = 0;
        if (v.e_trap == 4'd0)
            while (!ifa.op_ready && stall < 300) begin
                stall++;
                @(negedge clk);
            end
        chk("stall_cycles", r, 64'(stall), 64'(v.e_stall));
        chk("sp", r, 64'(ifa.sp), 64'(v.e_sp));
        chk("top", r, ifa.top, v.e_top);
        chk("top_type", r, 64'(ifa.top_type), 64'(v.e_type));
        chk("top_empty", r, 64'(ifa.top_empty), 64'(v.e_empty));
        chk("trap", r, 64'(ifa.trap), 64'(v.e_trap));
        chk("op_ready", r, 64'(ifa.op_ready), 64'(v.e_trap == 4'd0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        ifa.op = NOP; ifa.op_valid = 1'b0; ifa.op_data = '0; ifa.op_type = '0;
        ifa.op_index = '0; ifa.op_count = '0;
        ifb.op = NOP; ifb.op_valid = 1'b0; ifb.op_data = '0; ifb.op_type = '0;
        ifb.op_index = '0; ifb.op_count = '0;

        // Reset state and first-edge op_ready rise
        repeat (3) @(negedge clk);
        chk("rst_ready", -1, 64'(ifa.op_ready), 64'd0);
        chk("rst_sp", -1, 64'(ifa.sp), 64'd0);
        chk("rst_empty", -1, 64'(ifa.top_empty), 64'd1);
        chk("rst_trap", -1, 64'(ifa.trap), 64'd0);
        chk("rst_top", -1, ifa.top, 64'd0);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", -1, 64'(ifa.op_ready), 64'd0);
        @(posedge clk);
        #1 chk("ready_after_edge", -1, 64'(ifa.op_ready), 64'd1);

        //                rst op    data                     t  idx cnt  sp  top                      tt em tr st
        tbl.push_back(mk(1, PUSH, 64'd2,                   1, 0,  0,   1, 64'd2,                   1, 0, 0, 0));
        tbl.push_back(mk(0, PUSH, 64'hDEAD_BEEF_0000_0007, 0, 0,  0,   2, 64'd7,                   0, 0, 0, 0));
        tbl.push_back(mk(0, ENT,  64'd0,                   0, 2,  1,   3, 64'd0,                   0, 1, 0, 1));
        tbl.push_back(mk(0, GET,  64'd0,                   0, 0,  0,   4, 64'd2,                   1, 0, 0, 0));
        tbl.push_back(mk(0, PUSH, 64'hFFFF_FFFF_4040_0000, 2, 0,  0,   5, 64'h4040_0000,           2, 0, 0, 0));
        tbl.push_back(mk(0, SET,  64'd0,                   0, 1,  0,   4, 64'd2,                   1, 0, 0, 0));
        tbl.push_back(mk(0, GET,  64'd0,                   0, 1,  0,   5, 64'h4040_0000,           2, 0, 0, 0));
        tbl.push_back(mk(0, TEE,  64'd0,                   0, 2,  0,   5, 64'h4040_0000,           2, 0, 0, 0));
        tbl.push_back(mk(0, POP,  64'd0,                   0, 0,  0,   4, 64'd2,                   1, 0, 0, 0));
        tbl.push_back(mk(0, POP,  64'd0,                   0, 0,  0,   3, 64'd0,                   2, 1, 0, 0));
        tbl.push_back(mk(0, GET,  64'd0,                   0, 2,  0,   4, 64'h4040_0000,           2, 0, 0, 0));
        tbl.push_back(mk(0, LEV,  64'd0,                   0, 0,  0,   1, 64'h4040_0000,           2, 0, 0, 0));
        tbl.push_back(mk(0, LEV,  64'd0,                   0, 0,  0,   1, 64'h4040_0000,           2, 0, 6, 0));
        // LEAVE re-pushes the frame result over the caller's param slot
        tbl.push_back(mk(1, PUSH, 64'd9,                   0, 0,  0,   1, 64'd9,                   0, 0, 0, 0));
        tbl.push_back(mk(0, ENT,  64'd0,                   0, 1,  0,   1, 64'd0,                   0, 1, 0, 0));
        tbl.push_back(mk(0, PUSH, 64'd4,                   0, 0,  0,   2, 64'd4,                   0, 0, 0, 0));
        tbl.push_back(mk(0, TEE,  64'd0,                   0, 0,  0,   2, 64'd4,                   0, 0, 0, 0));
        tbl.push_back(mk(0, LEV,  64'd0,                   0, 0,  0,   1, 64'd4,                   0, 0, 0, 0));
        tbl.push_back(mk(0, LEV,  64'd0,                   0, 0,  0,   1, 64'd4,                   0, 0, 6, 0));
        // POP on empty stack
        tbl.push_back(mk(1, POP,  64'd0,                   0, 0,  0,   0, 64'd0,                   0, 1, 2, 0));
        // ENTER whose fill would pass capacity traps up front
        tbl.push_back(mk(1, PUSH, 64'd1,                   0, 0,  0,   1, 64'd1,                   0, 0, 0, 0));
        tbl.push_back(mk(0, PUSH, 64'd2,                   0, 0,  0,   2, 64'd2,                   0, 0, 0, 0));
        tbl.push_back(mk(0, ENT,  64'd0,                   0, 0,  255, 2, 64'd2,                   0, 0, 1, 0));
        // ENTER claiming more params than are on the stack
        tbl.push_back(mk(1, PUSH, 64'd1,                   0, 0,  0,   1, 64'd1,                   0, 0, 0, 0));
        tbl.push_back(mk(0, ENT,  64'd0,                   0, 2,  0,   1, 64'd1,                   0, 0, 2, 0));
        // SET with both out-of-range index and sp at locals_end: LOCAL_OOB wins
        tbl.push_back(mk(1, PUSH, 64'd1,                   0, 0,  0,   1, 64'd1,                   0, 0, 0, 0));
        tbl.push_back(mk(0, ENT,  64'd0,                   0, 1,  1,   2, 64'd0,                   0, 1, 0, 1));
        tbl.push_back(mk(0, SET,  64'd0,                   0, 3,  0,   2, 64'd0,                   0, 1, 3, 0));
        // Locals end at fp+2: GET 2 is out of range
        tbl.push_back(mk(1, ENT,  64'd0,                   0, 0,  2,   2, 64'd0,                   0, 1, 0, 2));
        tbl.push_back(mk(0, GET,  64'd0,                   0, 2,  0,   2, 64'd0,                   0, 1, 3, 0));

        for (int r = 0; r < tbl.size(); r++) run_vec(tbl[r], r);

        // Halted unit ignores a held request
        @(negedge clk);
        ifa.op = PUSH; ifa.op_data = 64'd77; ifa.op_type = 2'd0; ifa.op_valid = 1'b1;
        repeat (3) @(negedge clk);
        ifa.op_valid = 1'b0;
        chk("halt_sp", 200, 64'(ifa.sp), 64'd2);
        chk("halt_trap", 200, 64'(ifa.trap), 64'd3);
        chk("halt_ready", 200, 64'(ifa.op_ready), 64'd0);

        // Fill to capacity, overflow, then asynchronous reset
        do_reset();
        for (int k = 0; k < 256; k++) issue(PUSH, 64'(k), 2'd0, 8'd0, 8'd0, 300);
        @(negedge clk);
        chk("full_sp", 301, 64'(ifa.sp), 64'd0);
        chk("full_top", 301, ifa.top, 64'd255);
        chk("full_empty", 301, 64'(ifa.top_empty), 64'd0);
        chk("full_trap", 301, 64'(ifa.trap), 64'd0);
        issue(PUSH, 64'h1234, 2'd0, 8'd0, 8'd0, 302);
        @(negedge clk);
        chk("ovf_trap", 302, 64'(ifa.trap), 64'd1);
        chk("ovf_top", 302, ifa.top, 64'd255);
        chk("ovf_ready", 302, 64'(ifa.op_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_sp", 303, 64'(ifa.sp), 64'd0);
        chk("arst_trap", 303, 64'(ifa.trap), 64'd0);
        chk("arst_ready", 303, 64'(ifa.op_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Eight nested frames fit; the ninth ENTER is FRAME_OVF (beats its UNDERFLOW)
        for (int k = 0; k < 8; k++) issue(ENT, 64'd0, 2'd0, 8'd0, 8'd0, 400);
        @(negedge clk);
        chk("nest_trap", 400, 64'(ifa.trap), 64'd0);
        issue(ENT, 64'd0, 2'd0, 8'd5, 8'd0, 401);
        @(negedge clk);
        chk("fovf_trap", 401, 64'(ifa.trap), 64'd5);
        chk("fovf_sp", 401, 64'(ifa.sp), 64'd0);

        // Reset during FILL abandons the fill
        do_reset();
        issue(ENT, 64'd0, 2'd0, 8'd0, 8'd5, 500);
        repeat (2) @(negedge clk);
        chk("fill_sp", 500, 64'(ifa.sp), 64'd1);
        chk("fill_ready", 500, 64'(ifa.op_ready), 64'd0);
        rst_n = 1'b0;
        #1 chk("fill_rst_sp", 501, 64'(ifa.sp), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_fill_sp", 502, 64'(ifa.sp), 64'd0);
        chk("post_fill_ready", 502, 64'(ifa.op_ready), 64'd1);
        chk("post_fill_empty", 502, 64'(ifa.top_empty), 64'd1);

        // 32-bit-only instance
        do_reset();
        drive_b(64'd5, 2'd1);
        chk("no64_trap", 600, 64'(ifb.trap), 64'd4);
        chk("no64_sp", 600, 64'(ifb.sp), 64'd0);
        do_reset();
        drive_b(64'h1_0000_0005, 2'd0);
        chk("i32_sp", 601, 64'(ifb.sp), 64'd1);
        chk("i32_top", 601, ifb.top, 64'd5);
        chk("i32_trap", 601, 64'(ifb.trap), 64'd0);
        drive_b(64'd6, 2'd3);
        chk("f64_trap", 602, 64'(ifb.trap), 64'd4);
        chk("f64_sp", 602, 64'(ifb.sp), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wasm_local_stack.md
Name: wasm_local_stack

Overview:
- Parametrised operand-stack and locals unit for the wasm core.
- Supersedes the core's fixed single-frame local access with:
  - typed 32/64-bit entries;
  - nested call frames (ENTER/LEAVE) with multi-cycle zero-fill of declared locals;
  - a one-cycle op handshake;
  - trap reporting.
- Sits between the core's decode stage and its stack RAM; the core issues one op at a time and reads the top-of-stack outputs.

Parameters:
- STACK_DEPTH, 7, entry index width minus 1; capacity 2**(STACK_DEPTH+1) entries.
- FRAME_DEPTH, 3, saved-frame-pointer index width; max nesting 2**FRAME_DEPTH.
- USE_64B, 1, 1 = i64/f64 entries allowed; 0 = any 64-bit typed op traps NO_64B.
- TYPE_W, 2, type tag width (i32=0, i64=1, f32=2, f64=3).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- op  in  3  0 NOP, 1 PUSH, 2 POP, 3 GET_LOCAL, 4 SET_LOCAL, 5 TEE_LOCAL, 6 ENTER, 7 LEAVE.
- op_valid  in  1  op request.
- op_ready  out  1  unit accepts op this cycle.
- op_data  in  64  PUSH value.
- op_type  in  TYPE_W  PUSH type.
- op_index  in  STACK_DEPTH+1  local index (GET/SET/TEE); ENTER: param count.
- op_count  in  STACK_DEPTH+1  ENTER: extra locals to zero-fill.
- top  out  64  top-of-stack value; 0 when empty.
- top_type  out  TYPE_W  top-of-stack type.
- top_empty  out  1  stack empty, or sp == fp in current frame.
- sp  out  STACK_DEPTH+1  stack pointer (next free slot).
- trap  out  4  0 none, 1 OVERFLOW, 2 UNDERFLOW, 3 LOCAL_OOB, 4 NO_64B, 5 FRAME_OVF, 6 FRAME_UNF; sticky.

Behaviour:
- Reset (reset=0, async):
  - sp=0, fp=0, frame level 0, trap=0, state IDLE.
  - top=0, top_type=0, top_empty=1, op_ready=0 while in reset.
  - op_ready rises on the first clk edge after reset deasserts.
  - Reset mid-FILL abandons the fill immediately.
- States:
  - IDLE: op_ready=1 iff trap==0.
  - FILL: op_ready=0.
  - HALT: entered on any trap; op_ready=0 until reset.
- Accept: op_valid & op_ready at a rising edge. Every single-cycle op updates sp/top/top_type/top_empty on that edge.
- Entry storage: 64 data bits + type tag. i32/f32 values store upper 32 bits as 0. top is the registered cached copy of entry sp-1.
- PUSH: write {op_data, op_type} at sp, sp+1.
  - sp == capacity -> OVERFLOW.
  - USE_64B=0 with type 1 or 3 -> NO_64B.
- POP: sp-1.
  - sp == fp -> UNDERFLOW.
  - The new top comes from RAM and is valid at the same edge (RAM is read asynchronously, or the next-top is cached; either is acceptable as long as it is visible the cycle after accept).
- GET_LOCAL i: push copy of entry fp+i.
  - Requires fp+i < locals_end; locals_end = fp + params + count latched at ENTER. Otherwise LOCAL_OOB.
  - Also checks OVERFLOW.
- SET_LOCAL i: pop top into entry fp+i, keeping its type. Same OOB/UNDERFLOW checks.
- TEE_LOCAL i: as SET but sp unchanged.
- Local-region guard: sp must not fall below locals_end.
  - SET/TEE/POP with sp == locals_end -> UNDERFLOW.
  - top_empty=1 when sp == locals_end.
- ENTER p,c:
  - Push {fp, locals_end} onto frame stack.
  - fp = sp - p (p params already on stack); p > sp - locals_end -> UNDERFLOW.
  - If c==0: single cycle.
  - Else enter FILL: write {0, i32} at sp each cycle, sp+1, for c cycles, then IDLE. Exactly c cycles of op_ready=0.
  - Frame stack full -> FRAME_OVF.
  - sp+c > capacity -> OVERFLOW, detected at accept; no partial fill.
- LEAVE:
  - Result = current top if sp > locals_end, else none.
  - sp = fp; restore fp and locals_end from frame stack; re-push result (one cycle, single write).
  - Level 0 -> FRAME_UNF.
- Traps:
  - The trapping op has no architectural effect; trap is set on the accept edge.
  - The first trap wins; simultaneous conditions use priority NO_64B > FRAME_* > LOCAL_OOB > OVERFLOW > UNDERFLOW.
- op_valid while op_ready=0: ignored; requester holds.

Test Plan:
- Reset low 3 cycles, release -> sp=0, top_empty=1, trap=0, op_ready=1 next edge.
- PUSH i64 2, PUSH i32 7, ENTER p=2 c=1 -> op_ready low exactly 1 cycle, sp=3. Then GET_LOCAL 0 -> top=2, top_type=1, top_empty=0, sp=4.
- ENTER p=0 c=2 then GET_LOCAL 2 -> trap=3 (LOCAL_OOB), op_ready=0, sp unchanged; a subsequent PUSH is ignored.
- USE_64B=0: PUSH type 1 value 5 -> trap=4, sp=0. PUSH type 0 before it -> accepted.
- Fill to capacity (256 PUSHes, STACK_DEPTH=7), then PUSH -> trap=1, sp=256 wraps not allowed (sp holds 0 in its STACK_DEPTH+1 bits only if width permits; sp width sized so 256 representable requires STACK_DEPTH+2 internally; checked via full flag). Then reset mid-state -> sp=0, trap=0.
- PUSH 9, ENTER p=1 c=0, PUSH 4, TEE_LOCAL 0, LEAVE -> sp=1, top=4 (result re-pushed); LEAVE again -> trap=6.
